display_mux_7seg: RTL and testbench
===================================

DISPLAY_MUX_7SEG -- requirements
Module: display_mux_7seg

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50_000, meaning clocks each digit is driven per scan slot (legal: REFRESH_DIV >= 2).
REQ-002 SHALL have parameter BLANK_CYC, default 500, meaning clocks all anodes are off before each slot, for anti-ghosting (legal: BLANK_CYC >= 1).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load  input  1  one-clock strobe that captures d0..d3, dp_in and lz_en.
REQ-006 SHALL have ports d0, d1, d2, d3  input  4 each  BCD digits; d0 is least significant and d3 most significant.
REQ-007 SHALL have port dp_in  input  4  decimal-point request per digit; bit k maps to digit k.
REQ-008 SHALL have port lz_en  input  1  leading-zero blanking request.
REQ-009 SHALL have port disp_en  input  1  display enable, sampled live (not captured by load).
REQ-010 SHALL have port an  output  4  active-low anode selects; bit k drives digit k.
REQ-011 SHALL have port seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-012 SHALL have port dp  output  1  active-low decimal point.

Function
REQ-013 SHALL hold shadow registers for the digits, dp and lz; they update only on a clock edge where load=1.
REQ-014 SHALL NOT drive the pins directly from d0..d3; the pins show shadow contents only, so no tearing occurs while the inputs change.
REQ-015 SHALL cycle through slots 0,1,2,3,0,…; each slot is a GAP phase (BLANK_CYC clocks) followed by an ON phase (REFRESH_DIV clocks).
- Frame length: 4*(BLANK_CYC+REFRESH_DIV) clocks.
REQ-016 SHALL, during GAP: an=4'b1111, seg=7'h7F, dp=1.
REQ-017 SHALL, during ON of slot k with disp_en=1: an has only bit k low; seg=encode(shadow digit k); dp=~shadow_dp[k].
REQ-018 SHALL encode BCD as follows (active-low):
- 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
- 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
- values 10..15 display a dash: 7'h3F (g only).
REQ-019 SHALL, when shadow lz=1, blank leading zeros: digit k (k=3,2,1) is blanked if it and all higher digits are zero.
- Blanked digit: seg=7'h7F; its anode is still driven.
- Digit 0 is never blanked.
- dp follows shadow_dp regardless of blanking.
REQ-020 SHALL, when disp_en=0, hold an=4'b1111, seg=7'h7F and dp=1 while the scan timing keeps running.
- disp_en returning to 1 resumes output within the current slot with no phase reset.
REQ-021 SHALL register all outputs (no combinational path from any input to an/seg/dp).
- A change of shadow data or disp_en appears on the pins exactly one clock after the edge that captured or sampled it.
REQ-022 SHALL implement the slot/phase counter with at least 32 bits and no overflow for legal parameters.
- Wrap after slot 3 ON returns to slot 0 GAP with no extra cycle.
REQ-023 SHALL accept load on any cycle, including back-to-back and during GAP or ON; the last load wins.
REQ-024 SHALL never assert more than one anode low in any cycle.

Reset
REQ-025 SHALL, on a clock edge with reset=1:
- set an=4'b1111, seg=7'h7F, dp=1;
- clear shadow digits, dp and lz to 0;
- place the scan at the start of slot 0 GAP.
REQ-026 SHALL give reset priority over load when both are high.
- A mid-frame reset aborts the slot immediately; no partial slot completes.
REQ-027 SHALL, for the first edge with reset=0 (cycle 1):
- hold GAP for cycles 1..BLANK_CYC;
- drive an=4'b1110 for cycles BLANK_CYC+1 .. BLANK_CYC+REFRESH_DIV, showing digit 0 = "0" (seg=7'h40).

Verification (REFRESH_DIV=4, BLANK_CYC=2)
REQ-028 SHALL cover the scan order:
- Stimulus: reset, then load d3..d0=1,2,3,4.
- Response: an repeats 1111×2, 1110×4, 1111×2, 1101×4, 1111×2, 1011×4, 1111×2, 0111×4 (24-clock frame).
- Response: seg 7'h19, 7'h30, 7'h24, 7'h79 in respective ON phases.
REQ-029 SHALL cover leading-zero blanking:
- Stimulus: load d3..d0=0,0,7,0 with lz_en=1.
- Response: slots 3 and 2 give seg=7'h7F; slot 1 gives 7'h78; slot 0 gives 7'h40.
- Stimulus: reload with lz_en=0.
- Response: slots 3 and 2 give 7'h40.
REQ-030 SHALL cover invalid digits and decimal points:
- Stimulus: d0=4'hC, dp_in=4'b0001.
- Response: slot 0 gives seg=7'h3F and dp=0; other slots give dp=1.
REQ-031 SHALL cover disp_en:
- Stimulus: drop disp_en mid ON-slot 1.
- Response: an=1111 from the next clock onward.
- Stimulus: raise disp_en again.
- Response: the an pattern resumes, aligned to the unchanged frame count.
REQ-032 SHALL cover load during ON:
- Stimulus: change d0 from 5 to 9 via load in ON-slot 0, cycle 2.
- Response: seg goes 7'h12 to 7'h10 one clock later.
- Response: no other digit is affected.
REQ-033 SHALL cover reset mid-frame:
- Stimulus: assert reset during slot 2 ON, together with load=1.
- Response: next clock shows an=1111, seg=7'h7F and shadow=0.
- Response: after release, the REQ-027 sequence recurs.

Source files
------------

// File: rtl/display_mux_7seg.sv
// ---------------------------------------------------------------------------
// display_mux_7seg
//
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Digit data, decimal points and the leading-zero request are captured into
// shadow registers on a load strobe. The scan shows only the shadow copy, so
// the pins never tear while the inputs change. Each digit slot starts with a
// blanking gap (all anodes off) and is followed by an on-time. Every output
// is registered.
//
// Parameters
//   REFRESH_DIV  clocks each digit is driven per slot       (>= 2)
//   BLANK_CYC    clocks all anodes are off before each slot (>= 1)
//
// Ports
//   clk      in   1  system clock, rising edge
//   reset    in   1  synchronous, active-high reset
//   load     in   1  strobe capturing d0..d3, dp_in, lz_en
//   d0..d3   in   4  BCD digits, d0 least significant
//   dp_in    in   4  decimal point request, bit k -> digit k
//   lz_en    in   1  leading-zero blanking request
//   disp_en  in   1  display enable, sampled every clock
//   an       out  4  active-low anode selects, bit k -> digit k
//   seg      out  7  active-low segments {g,f,e,d,c,b,a}
//   dp       out  1  active-low decimal point
// ---------------------------------------------------------------------------
module display_mux_7seg #(
  parameter int REFRESH_DIV = 50_000,
  parameter int BLANK_CYC   = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] dp_in,
  input  logic       lz_en,
  input  logic       disp_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  // Terminal counts of the phase counter, held at full counter width so the
  // comparison never truncates a large parameter value.
  localparam logic [31:0] GAP_LAST = 32'(BLANK_CYC - 1);
  localparam logic [31:0] ON_LAST  = 32'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic {
    ST_GAP = 1'b0,
    ST_ON  = 1'b1
  } state_t;

  // BCD to active-low segment pattern; non-decimal codes show a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

  // Shadow registers
  logic [3:0][3:0] r_dig;
  logic [3:0]      r_dp_sh;
  logic            r_lz;
  logic            r_en;

  // Scan state
  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_slot;
  logic [1:0]  w_slot_nxt;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_nxt;

  // Output registers
  logic [3:0] r_an;
  logic [6:0] r_seg;
  logic       r_dp;

  // Digit selection and leading-zero logic
  logic [3:0] w_digit;
  logic       w_dp_sel;
  logic [3:0] w_blank;
  logic       w_drive;

  // ---- shadow capture: load is the only path from the inputs to display data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dig   <= '0;
      r_dp_sh <= '0;
      r_lz    <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      // disp_en goes through one register so it reaches the pins with the
      // same one-clock latency as loaded data.
      r_en <= disp_en;
      if (load) begin
        r_dig   <= {d3, d2, d1, d0};
        r_dp_sh <= dp_in;
        r_lz    <= lz_en;
      end
    end
  end

  // ---- scan FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_GAP;
      r_slot  <= 2'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---- scan FSM: next state. The 2-bit slot wraps 3 -> 0 naturally, so the
  // frame closes without an extra cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_cnt_nxt   = r_cnt + 32'd1;
    case (r_state)
      ST_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = ST_ON;
          w_cnt_nxt   = '0;
        end
      end
      ST_ON: begin
        if (r_cnt == ON_LAST) begin
          w_state_nxt = ST_GAP;
          w_slot_nxt  = r_slot + 2'd1;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_GAP;
        w_slot_nxt  = 2'd0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A digit is a leading zero when it and every more significant digit are
  // zero. Digit 0 always shows so a zero value never renders as all-dark.
  always_comb begin
    w_blank[3] = r_lz && (r_dig[3] == 4'd0);
    w_blank[2] = w_blank[3] && (r_dig[2] == 4'd0);
    w_blank[1] = w_blank[2] && (r_dig[1] == 4'd0);
    w_blank[0] = 1'b0;
  end

  assign w_digit  = r_dig[r_slot];
  assign w_dp_sel = r_dp_sh[r_slot];
  assign w_drive  = (r_state == ST_ON) && r_en;

  // ---- output register: one anode at most, decoded from the 2-bit slot
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else if (w_drive) begin
      r_an  <= ~(4'b0001 << r_slot);
      r_seg <= w_blank[r_slot] ? SEG_BLANK : bcd_to_seg(w_digit);
      r_dp  <= ~w_dp_sel;
    end else begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_display_mux_7seg.sv
// ---------------------------------------------------------------------------
// tb_display_mux_7seg
//
// Directed bench for display_mux_7seg with REFRESH_DIV=4, BLANK_CYC=2
// (24-clock frame). A table of load vectors with hand-computed per-slot
// segment/dp patterns is replayed frame by frame; hand sequences cover
// disp_en gating, load during an on-time, back-to-back loads and reset in
// the middle of a frame.
// ---------------------------------------------------------------------------
module tb_display_mux_7seg;

  localparam int RDIV  = 4;
  localparam int BCYC  = 2;
  localparam int SLOT  = RDIV + BCYC;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] dp_in;
  logic       lz_en;
  logic       disp_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  display_mux_7seg #(.REFRESH_DIV(RDIV), .BLANK_CYC(BCYC)) dut (
    .clk(clk), .reset(reset), .load(load),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .dp_in(dp_in), .lz_en(lz_en), .disp_en(disp_en),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [15:0] dig;   // {d3,d2,d1,d0}
    logic [3:0]  dpi;
    logic        lz;
    logic [27:0] segx;  // {slot3,slot2,slot1,slot0}
    logic [3:0]  dpx;   // expected active-low dp per slot
  } vec_t;

  vec_t vecs [7];

  // One clock: inputs are driven at the falling edge, outputs sampled there.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  function automatic int pos();
    return (cyc - 1) % FRAME;
  endfunction

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d pos=%0d got=%h want=%h", nm, cyc, pos(), act, exp);
    end
  endtask

  // Step one clock and compare against the frame position model.
  task automatic step_check(input logic en, input logic [27:0] segx, input logic [3:0] dpx);
    int         p, s;
    bit         on;
    logic [3:0] oh;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    step();
    p  = pos();
    s  = p / SLOT;
    on = ((p % SLOT) >= BCYC) && en;
    oh = 4'b0001 << s;
    an_e  = on ? ~oh : 4'b1111;
    seg_e = on ? segx[7*s +: 7] : 7'h7F;
    dp_e  = on ? dpx[s] : 1'b1;
    chk("an",  {3'b000, an},  {3'b000, an_e});
    chk("seg", seg,           seg_e);
    chk("dp",  {6'd0, dp},    {6'd0, dp_e});
  endtask

  // Advance until the next edge begins a new frame.
  task automatic align();
    while ((cyc % FRAME) != 0) step();
  endtask

  // One full frame with the data inputs scrambled (load low) every clock.
  task automatic check_frame(input logic [27:0] segx, input logic [3:0] dpx);
    for (int i = 0; i < FRAME; i++) begin
      d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
      dp_in = 4'($urandom); lz_en = 1'($urandom);
      step_check(1'b1, segx, dpx);
    end
  endtask

  task automatic do_load(input logic [15:0] dig, input logic [3:0] dpi, input logic lz);
    {d3, d2, d1, d0} = dig;
    dp_in = dpi;
    lz_en = lz;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    chk("rst_an",  {3'b000, an}, 7'h0F);
    chk("rst_seg", seg,          7'h7F);
    chk("rst_dp",  {6'd0, dp},   7'h01);
    reset = 1'b0;
    cyc   = 0;
  endtask

  localparam logic [27:0] ZEROS = {7'h40, 7'h40, 7'h40, 7'h40};

  initial begin
    vecs[0] = '{"scan_1234",  16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
    vecs[1] = '{"lz_0070",    16'h0070, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b1111};
    vecs[2] = '{"nolz_0070",  16'h0070, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h78, 7'h40}, 4'b1111};
    vecs[3] = '{"dash_dp0",   16'h000C, 4'b0001, 1'b0, {7'h40, 7'h40, 7'h40, 7'h3F}, 4'b1110};
    vecs[4] = '{"dash_lz",    16'h000C, 4'b0001, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h3F}, 4'b1110};
    vecs[5] = '{"mix_5689",   16'h5689, 4'b1010, 1'b1, {7'h12, 7'h02, 7'h00, 7'h10}, 4'b0101};
    vecs[6] = '{"lz_0900",    16'h0900, 4'b0000, 1'b1, {7'h7F, 7'h10, 7'h40, 7'h40}, 4'b1111};

    reset = 1'b1; load = 1'b0; disp_en = 1'b1;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0; dp_in = '0; lz_en = 1'b0;

    // Reset state, then the post-reset frame: gap, then digit 0 showing "0".
    do_reset();
    check_frame(ZEROS, 4'b1111);

    // Table-driven load vectors, each checked over a whole frame.
    for (int v = 0; v < 7; v++) begin
      do_load(vecs[v].dig, vecs[v].dpi, vecs[v].lz);
      align();
      check_frame(vecs[v].segx, vecs[v].dpx);
    end

    // disp_en dropped in slot 1 on-time, restored before slot 2 of next frame.
    do_load(16'h1234, 4'b0000, 1'b0);
    align();
    for (int i = 0; i <= 8; i++) step_check(1'b1, vecs[0].segx, 4'b1111);
    disp_en = 1'b0;
    step();
    for (int i = 10; i < FRAME; i++) step_check(1'b0, vecs[0].segx, 4'b1111);
    for (int i = 0; i <= 12; i++) step_check(1'b0, vecs[0].segx, 4'b1111);
    disp_en = 1'b1;
    for (int i = 13; i < FRAME; i++) step_check(1'b1, vecs[0].segx, 4'b1111);

    // Load during slot 0 on-time: d0 5 -> 9, other digits unchanged.
    do_load(16'h1235, 4'b0000, 1'b0);
    align();
    for (int i = 0; i <= 2; i++) step_check(1'b1, {7'h79, 7'h24, 7'h30, 7'h12}, 4'b1111);
    {d3, d2, d1, d0} = 16'h1239;
    load = 1'b1;
    step_check(1'b1, {7'h79, 7'h24, 7'h30, 7'h12}, 4'b1111);
    load = 1'b0;
    for (int i = 4; i < FRAME; i++) step_check(1'b1, {7'h79, 7'h24, 7'h30, 7'h10}, 4'b1111);

    // Back-to-back loads: the second wins; dp follows a blanked digit.
    do_load(16'h8888, 4'b1111, 1'b0);
    do_load(16'h0006, 4'b0100, 1'b1);
    align();
    check_frame({7'h7F, 7'h7F, 7'h7F, 7'h02}, 4'b1011);

    // Reset with load in slot 2 on-time: blank next clock, shadow cleared.
    align();
    for (int i = 0; i < 15; i++) step();
    {d3, d2, d1, d0} = 16'h9999;
    dp_in = 4'b1111; lz_en = 1'b1;
    reset = 1'b1; load = 1'b1;
    step();
    chk("midrst_an",  {3'b000, an}, 7'h0F);
    chk("midrst_seg", seg,          7'h7F);
    chk("midrst_dp",  {6'd0, dp},   7'h01);
    reset = 1'b0; load = 1'b0;
    cyc = 0;
    check_frame(ZEROS, 4'b1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
